// File: rtl/picosoc_bus_arbiter_pkg.sv
// Shared definitions for the PicoSoC native-bus round-robin arbiter:
// bus widths, the default error read data and the arbiter FSM state type.
package picosoc_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/picosoc_bus_arbiter_if.sv
// Native memory bus bundle: packed per-master request side plus the single slave side.
// The master modport is the arbiter's view; the slave modport is the surrounding SoC's view.
interface picosoc_bus_arbiter_if
  import picosoc_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2
);

  logic [NUM_MASTERS-1:0]        m_valid;
  logic [NUM_MASTERS-1:0]        m_ready;
  logic [ADDR_W*NUM_MASTERS-1:0] m_addr;
  logic [DATA_W*NUM_MASTERS-1:0] m_wdata;
  logic [STRB_W*NUM_MASTERS-1:0] m_wstrb;
  logic [DATA_W-1:0]             m_rdata;

  logic                          s_valid;
  logic                          s_ready;
  logic [ADDR_W-1:0]             s_addr;
  logic [DATA_W-1:0]             s_wdata;
  logic [STRB_W-1:0]             s_wstrb;
  logic [DATA_W-1:0]             s_rdata;

  modport master (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_addr, s_wdata, s_wstrb
  );

endinterface

// File: rtl/picosoc_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly after `last`, wrapping.
module picosoc_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [1:0]   last,
  output logic [1:0]   grant,
  output logic         any
);

  always_comb begin
    grant = '0;
    any   = 1'b0;
    // Nearest offset wins; inner loop keeps every req index constant.
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!any && req[i] && (i == (32'(last) + k) % N)) begin
          grant = 2'(i);
          any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/picosoc_bus_arbiter.sv
// Round-robin arbiter sharing one PicoSoC native bus between NUM_MASTERS requesters,
// with a watchdog that force-completes transactions to hung or unmapped slaves.
module picosoc_bus_arbiter
  import picosoc_bus_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_MASTERS    = 2,
  parameter int unsigned       TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  clk,
  input  logic                  resetn,
  picosoc_bus_arbiter_if.master bus,
  output logic [1:0]            grant_id,
  output logic                  err_pulse,
  output logic                  err_flag,
  output logic [ADDR_W-1:0]     err_addr,
  input  logic                  err_clr
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t           state;
  logic [1:0]       grant;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;

  logic [1:0]        pick;
  logic              pick_any;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;
  logic              done;
  logic              timeout;
  logic              complete;
  logic              drop;

  picosoc_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req   (bus.m_valid),
    .last  (last),
    .grant (pick),
    .any   (pick_any)
  );

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant == 2'(i)) begin
        sel_valid = bus.m_valid[i];
        sel_addr  = bus.m_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = bus.m_wdata[DATA_W*i +: DATA_W];
        sel_wstrb = bus.m_wstrb[STRB_W*i +: STRB_W];
      end
    end
  end

  always_comb begin
    bus.s_valid = (state == BUSY) && sel_valid;
    bus.s_addr  = sel_addr;
    bus.s_wdata = sel_wdata;
    bus.s_wstrb = sel_wstrb;
    done        = bus.s_valid && bus.s_ready;
    // A slave response in the final watchdog cycle takes priority over the timeout.
    timeout     = (TIMEOUT_CYCLES != 0) && bus.s_valid && !bus.s_ready &&
                  (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    complete    = done || timeout;
    drop        = (state == BUSY) && !sel_valid;
    err_pulse   = timeout;
    bus.m_rdata = timeout ? ERR_RDATA : bus.s_rdata;
    bus.m_ready = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      bus.m_ready[i] = complete && (grant == 2'(i));
    end
  end

  assign grant_id = grant;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= 2'(NUM_MASTERS - 1);
      cnt      <= '0;
      err_flag <= 1'b0;
      err_addr <= '0;
    end else begin
      if (timeout) begin
        err_flag <= 1'b1;
        err_addr <= bus.s_addr;
      end else if (err_clr) begin
        err_flag <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant <= pick;
            last  <= pick;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (complete || drop) begin
            state <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Directed bench for picosoc_bus_arbiter: single read, contention, write mux,
// watchdog timeout and clear, s_ready/timeout race, and reset during a transaction.
module tb_picosoc_bus_arbiter;

  logic        clk;
  logic        resetn;
  logic [1:0]  grant_id;
  logic        err_pulse;
  logic        err_flag;
  logic [31:0] err_addr;
  logic        err_clr;

  int unsigned tests;
  int unsigned fails;

  picosoc_bus_arbiter_if #(.NUM_MASTERS(2)) bus ();

  picosoc_bus_arbiter #(
    .NUM_MASTERS    (2),
    .TIMEOUT_CYCLES (8),
    .ERR_RDATA      (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .grant_id  (grant_id),
    .err_pulse (err_pulse),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0]  exp_g;
    logic [31:0] exp_a;
    tests = 0;
    fails = 0;
    resetn = 1'b0;
    err_clr = 1'b0;
    bus.m_valid = '0;
    bus.m_addr = '0;
    bus.m_wdata = '0;
    bus.m_wstrb = '0;
    bus.s_ready = 1'b0;
    bus.s_rdata = '0;
    #12;
    chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rst_m_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_err_flag", 32'(err_flag), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    tick();
    resetn = 1'b1;

    // Single master read: IDLE + 3 BUSY cycles, completion on the 4th cycle
    tick();
    bus.m_valid = 2'b01;
    bus.m_addr[31:0] = 32'h0000_0010;
    #1 chk("single_idle_s_valid", 32'(bus.s_valid), 32'd0);
    tick();
    chk("single_busy_s_valid", 32'(bus.s_valid), 32'd1);
    chk("single_s_addr", bus.s_addr, 32'h0000_0010);
    chk("single_m_ready_c1", 32'(bus.m_ready), 32'd0);
    tick();
    chk("single_m_ready_c2", 32'(bus.m_ready), 32'd0);
    tick();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h1234_5678;
    #1 chk("single_m_ready_c3", 32'(bus.m_ready), 32'd1);
    chk("single_m_rdata", bus.m_rdata, 32'h1234_5678);
    tick();
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b0;
    #1 chk("single_after_m_ready", 32'(bus.m_ready), 32'd0);

    // Contention: last=0, so grants go 1,0,1,0 with an always-ready slave
    bus.m_valid = 2'b11;
    bus.m_addr = {32'h0000_0104, 32'h0000_0100};
    bus.s_ready = 1'b1;
    exp_g = 2'd1;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_a = (exp_g == 2'd1) ? 32'h0000_0104 : 32'h0000_0100;
      chk("rr_grant_id", 32'(grant_id), 32'(exp_g));
      chk("rr_m_ready", 32'(bus.m_ready), (exp_g == 2'd1) ? 32'd2 : 32'd1);
      chk("rr_s_addr", bus.s_addr, exp_a);
      tick();
      chk("rr_idle_m_ready", 32'(bus.m_ready), 32'd0);
      exp_g = ~exp_g & 2'b01;
    end
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b0;

    // Write passthrough from m1, with distinct m0 values to expose a wrong mux
    tick();
    bus.m_valid = 2'b10;
    bus.m_addr = {32'h0200_0008, 32'hAAAA_0000};
    bus.m_wdata = {32'hCAFE_F00D, 32'h1111_1111};
    bus.m_wstrb = {4'b0011, 4'b1111};
    tick();
    chk("wr_s_valid", 32'(bus.s_valid), 32'd1);
    chk("wr_grant_id", 32'(grant_id), 32'd1);
    chk("wr_s_addr", bus.s_addr, 32'h0200_0008);
    chk("wr_s_wdata", bus.s_wdata, 32'hCAFE_F00D);
    chk("wr_s_wstrb", 32'(bus.s_wstrb), 32'h3);
    bus.s_ready = 1'b1;
    #1 chk("wr_m_ready", 32'(bus.m_ready), 32'd2);
    tick();
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b0;
    bus.m_wstrb = '0;

    // Timeout on m0 after 8 BUSY cycles with a silent slave
    tick();
    bus.m_valid = 2'b01;
    bus.m_addr[31:0] = 32'h0300_0000;
    bus.s_rdata = 32'h5555_5555;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 7) begin
        chk("to_m_ready_c7", 32'(bus.m_ready), 32'd0);
        chk("to_err_pulse_c7", 32'(err_pulse), 32'd0);
      end
    end
    chk("to_m_ready_c8", 32'(bus.m_ready), 32'd1);
    chk("to_m_rdata", bus.m_rdata, 32'hDEAD_BEEF);
    chk("to_err_pulse_c8", 32'(err_pulse), 32'd1);
    tick();
    bus.m_valid = 2'b00;
    #1 chk("to_err_pulse_after", 32'(err_pulse), 32'd0);
    chk("to_err_flag", 32'(err_flag), 32'd1);
    chk("to_err_addr", err_addr, 32'h0300_0000);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_err_clr", 32'(err_flag), 32'd0);

    // s_ready arrives in the exact timeout cycle: normal completion wins
    bus.m_valid = 2'b01;
    bus.m_addr[31:0] = 32'h0300_0004;
    tick();
    for (int c = 1; c < 8; c++) tick();
    bus.s_ready = 1'b1;
    bus.s_rdata = 32'h0BAD_F00D;
    #1 chk("race_m_ready", 32'(bus.m_ready), 32'd1);
    chk("race_m_rdata", bus.m_rdata, 32'h0BAD_F00D);
    chk("race_err_pulse", 32'(err_pulse), 32'd0);
    tick();
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b0;
    #1 chk("race_err_flag", 32'(err_flag), 32'd0);

    // Reset while m1 is waiting in BUSY
    bus.m_valid = 2'b10;
    tick();
    chk("rb_grant_id", 32'(grant_id), 32'd1);
    chk("rb_s_valid", 32'(bus.s_valid), 32'd1);
    bus.s_ready = 1'b1;
    resetn = 1'b0;
    #1 chk("rb_s_valid_rst", 32'(bus.s_valid), 32'd0);
    chk("rb_m_ready_rst", 32'(bus.m_ready), 32'd0);
    chk("rb_grant_id_rst", 32'(grant_id), 32'd0);
    tick();
    resetn = 1'b1;
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b11;
    tick();
    chk("rb_first_grant", 32'(grant_id), 32'd0);
    bus.s_ready = 1'b1;
    #1 chk("rb_first_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    bus.m_valid = 2'b00;
    bus.s_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
